sensor_config: RTL and testbench
================================

SENSOR_CONFIG -- requirements
Module: sensor_config

Configures the wireless IMU at power-up or on request by sending register-write commands (0xFF 0xAA reg dataL dataH) through a byte-wide UART transmitter.

Interface
REQ-001 Parameter GAP_CYCLES, default 500000, meaning idle clk cycles inserted after each complete command.
REQ-002 Parameter CONTENT_WORD, default 16'h000A, meaning value for register 0x02 (acceleration + angle output enabled).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  single-cycle request to run the configuration sequence.
REQ-006 rate  input  4  output-rate code for register 0x03.
REQ-007 tx_busy  input  1  transmitter busy; high while a byte is being shifted out.
REQ-008 tx_start  output  1  single-cycle pulse telling the transmitter to load tx_data.
REQ-009 tx_data  output  8  byte to transmit.
REQ-010 busy  output  1  high from accepted start until done.
REQ-011 done  output  1  single-cycle pulse when the sequence completes.

Function
REQ-012 The sequence SHALL be four 5-byte commands, in order: unlock FF AA 69 88 B5; content FF AA 02 CONTENT_WORD[7:0] CONTENT_WORD[15:8]; rate FF AA 03 {4'h0,rate_q} 00; save FF AA 00 00 00.
REQ-013 The block SHALL latch rate into rate_q in the cycle start is accepted; later rate changes have no effect on the running sequence.
REQ-014 States SHALL be IDLE, SEND, WAIT_ACK, WAIT_TX, GAP, DONE.
REQ-015 IDLE: start=1 -> SEND, cmd_idx=0, byte_idx=0, busy=1 from next cycle; start=0 -> stay.
REQ-016 SEND: if tx_busy=0, assert tx_start for exactly one cycle with tx_data = byte(cmd_idx, byte_idx), then go to WAIT_ACK; if tx_busy=1, wait in SEND with tx_start=0.
REQ-017 WAIT_ACK: stay until tx_busy=1, then go to WAIT_TX; if tx_busy stays 0 for 4 cycles, return to SEND and resend the same byte.
REQ-018 WAIT_TX: stay until tx_busy=0; then if byte_idx<4, increment byte_idx and go to SEND; else go to GAP with gap counter cleared.
REQ-019 GAP: count GAP_CYCLES cycles; at terminal count, if cmd_idx<3, increment cmd_idx, set byte_idx=0, and go to SEND; else go to DONE.
REQ-020 DONE: pulse done for one cycle, clear busy, return to IDLE.
REQ-021 tx_data SHALL hold its value from the tx_start cycle until the next tx_start.
REQ-022 start while busy=1 SHALL be ignored, with no restart and no queueing.
REQ-023 start in the same cycle as DONE SHALL be ignored; a start in the following IDLE cycle is accepted.
REQ-024 The gap counter SHALL be wide enough for GAP_CYCLES with no wrap-around; GAP_CYCLES=0 SHALL be treated as 1.
REQ-025 tx_start SHALL never be asserted in any cycle where tx_busy=1.
REQ-026 Total bytes per run SHALL be exactly 20; done SHALL follow the last GAP.

Reset
REQ-027 On rst=1, regardless of clk, the block SHALL immediately enter IDLE with tx_start=0, tx_data=8'h00, busy=0, done=0, cmd_idx=0, byte_idx=0, gap counter=0, rate_q=0.
REQ-028 Reset mid-sequence SHALL abandon the sequence with no resume; a new start restarts at the unlock command.
REQ-029 After rst deasserts, the block SHALL accept start on the first clk edge.

Verification
REQ-030 Start with GAP_CYCLES=8, rate=4'h6, and a transmitter model with busy=10 cycles -> exactly 20 tx_start pulses carrying FF AA 69 88 B5 FF AA 02 0A 00 FF AA 03 06 00 FF AA 00 00 00, then one done pulse, then busy=0.
REQ-031 Change rate to 4'h9 after start -> byte 14 is still 06.
REQ-032 Hold tx_busy=1 for 50 cycles at start -> no tx_start until tx_busy falls; first byte FF is sent afterwards.
REQ-033 Model drops the first tx_start (busy never rises) -> FF is resent after 4 cycles; sequence otherwise unchanged.
REQ-034 Pulse start again during command 2 -> ignored, total of 20 bytes and one done.
REQ-035 Assert rst asynchronously during byte 7 -> outputs are at reset values before the next clk edge; a new start begins with FF AA 69.

Source files
------------

// File: rtl/sensor_config.sv
// IMU configurator: on start, streams four FF AA reg lo hi write commands through a byte UART, with an idle gap after each.
// tx_start is a registered pulse issued only while tx_busy is low; an unacknowledged byte is resent after four idle cycles.
module sensor_config #(
    parameter int unsigned GAP_CYCLES   = 500000,
    parameter logic [15:0] CONTENT_WORD = 16'h000A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rate,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done
);
    localparam int unsigned GAP_EFF = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned GAP_W   = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_TX, GAP, DONE} state_t;

    state_t           state;
    logic [1:0]       cmd_idx;
    logic [2:0]       byte_idx;
    logic [1:0]       ack_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       rate_q;

    function automatic logic [7:0] cmd_byte(input logic [1:0] cmd, input logic [2:0] idx,
                                            input logic [3:0] rq);
        logic [7:0] reg_addr;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] b;
        case (cmd)
            2'd0: begin reg_addr = 8'h69; lo = 8'h88;              hi = 8'hB5;              end
            2'd1: begin reg_addr = 8'h02; lo = CONTENT_WORD[7:0];  hi = CONTENT_WORD[15:8]; end
            2'd2: begin reg_addr = 8'h03; lo = {4'h0, rq};         hi = 8'h00;              end
            default: begin reg_addr = 8'h00; lo = 8'h00;           hi = 8'h00;              end
        endcase
        case (idx)
            3'd0:    b = 8'hFF;
            3'd1:    b = 8'hAA;
            3'd2:    b = reg_addr;
            3'd3:    b = lo;
            default: b = hi;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            cmd_idx  <= 2'd0;
            byte_idx <= 3'd0;
            ack_cnt  <= 2'd0;
            gap_cnt  <= '0;
            rate_q   <= 4'h0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SEND;
                        cmd_idx  <= 2'd0;
                        byte_idx <= 3'd0;
                        busy     <= 1'b1;
                        rate_q   <= rate;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= cmd_byte(cmd_idx, byte_idx, rate_q);
                        ack_cnt  <= 2'd0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A transmitter that never raises busy has dropped the byte: retry it.
                    if (tx_busy) begin
                        state <= WAIT_TX;
                    end else if (ack_cnt == 2'd3) begin
                        state <= SEND;
                    end else begin
                        ack_cnt <= ack_cnt + 2'd1;
                    end
                end
                WAIT_TX: begin
                    if (!tx_busy) begin
                        if (byte_idx < 3'd4) begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= SEND;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (cmd_idx != 2'd3) begin
                            cmd_idx  <= cmd_idx + 2'd1;
                            byte_idx <= 3'd0;
                            state    <= SEND;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sensor_config.sv
// Bench for sensor_config: negedge transmitter model with busy window, scoreboard of expected bytes.
module tb_sensor_config;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] rate;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] exp_q[$];
    int cyc        = 0;
    int n_starts   = 0;
    int n_acc      = 0;
    int n_done     = 0;
    int busy_left  = 0;
    int hold_until = 0;
    int drop_at    = -1;
    int drop_cyc   = 0;
    bit drop_pend  = 0;

    sensor_config #(.GAP_CYCLES(8), .CONTENT_WORD(16'h000A)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rate     (rate),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [3:0] r);
        logic [7:0] seq [20];
        seq = '{8'hFF, 8'hAA, 8'h69, 8'h88, 8'hB5,
                8'hFF, 8'hAA, 8'h02, 8'h0A, 8'h00,
                8'hFF, 8'hAA, 8'h03, {4'h0, r}, 8'h00,
                8'hFF, 8'hAA, 8'h00, 8'h00, 8'h00};
        return seq[i];
    endfunction

    // Transmitter model and scoreboard consumer, evaluated mid-cycle.
    always @(negedge clk) begin
        bit accept;
        accept = 0;
        cyc++;
        if (rst) begin
            busy_left = 0;
            drop_pend = 0;
            tx_busy   = 1'b0;
        end else begin
            if (tx_start) begin
                check("no_start_while_busy", tx_busy, 0);
                check("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q[0]);
                if (n_starts == drop_at) begin
                    drop_pend = 1;
                    drop_cyc  = cyc;
                end else begin
                    if (drop_pend) begin
                        check("resend_gap", cyc - drop_cyc, 5);
                        drop_pend = 0;
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    accept = 1;
                    n_acc++;
                end
                n_starts++;
            end
            if (done) begin
                n_done++;
                check("done_after_last_byte", exp_q.size(), 0);
            end
            if (busy_left > 0) busy_left--;
            if (accept) busy_left = 10;
            tx_busy = (busy_left > 0) || (cyc < hold_until);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [3:0] r, input logic [3:0] r_after, input int hold,
                           input bit drop, input int restart_at);
        int base, acc0, d0;
        bit pulsed;
        base = n_starts;
        acc0 = n_acc;
        d0 = n_done;
        pulsed = 0;
        for (int i = 0; i < 20; i++) exp_q.push_back(exp_byte(i, r));
        if (drop) drop_at = n_starts;
        if (hold > 0) hold_until = cyc + hold + 1;
        rate = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        rate = r_after;
        check("busy_after_start", busy, 1);
        if (hold > 0) begin
            for (int i = 0; i < hold - 2; i++) tick();
            check("no_start_during_hold", n_starts - base, 0);
        end
        for (int t = 0; t < 3000 && n_done == d0; t++) begin
            tick();
            if (restart_at >= 0 && !pulsed && n_starts - base == restart_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                pulsed = 1;
            end
        end
        check("done_seen", n_done - d0, 1);
        check("bytes_accepted", n_acc - acc0, 20);
        check("tx_start_total", n_starts - base, drop ? 21 : 20);
        tick();
        check("busy_cleared", busy, 0);
        check("done_single_cycle", done, 0);
        for (int i = 0; i < 30; i++) tick();
        check("no_extra_done", n_done - d0, 1);
        check("no_extra_bytes", n_starts - base, drop ? 21 : 20);
        drop_at = -1;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        start = 1'b0;
        rate = 4'h0;
        #2;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        tick();
        rst = 1'b0;

        run_seq(4'h6, 4'h6, 0, 0, -1);
        run_seq(4'h6, 4'h9, 0, 0, -1);
        run_seq(4'h6, 4'h6, 50, 0, -1);
        run_seq(4'h6, 4'h6, 0, 1, -1);
        run_seq(4'h6, 4'h6, 0, 0, 6);
        run_seq(4'hC, 4'h6, 0, 0, -1);

        base = n_starts;
        for (int i = 0; i < 20; i++) exp_q.push_back(exp_byte(i, 4'h6));
        rate = 4'h6;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 1000 && n_starts - base < 7; t++) tick();
        check("reached_byte7", n_starts - base, 7);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_tx_start", tx_start, 0);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        run_seq(4'h6, 4'h6, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
